// File: rtl/rgb_pixel_source.sv
// rgb_pixel_source: streams packed RGB pixels from a sync ROM into three independent busy/vld channel FIFOs.
// Define RGB_PIXEL_SOURCE_GRAY_EN to push luminance Y=(R+2G+B)>>2 on all channels instead of raw components.
module rgb_pixel_source #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_frame_len,
  output logic              o_active,
  output logic              o_done,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [23:0]       i_mem_rdata,
  output logic              o_r_vld,
  output logic [7:0]        o_r_data,
  input  logic              i_r_busy,
  output logic              o_g_vld,
  output logic [7:0]        o_g_data,
  input  logic              i_g_busy,
  output logic              o_b_vld,
  output logic [7:0]        o_b_data,
  input  logic              i_b_busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic              pend_q, done_q, active_q, start_w;
  logic [2:0]        busy_w, vld_w, room_w, empty_w;
  logic [2:0][7:0]   push_w, head_w;

  assign busy_w     = {i_b_busy, i_g_busy, i_r_busy};
  assign start_w    = state_q == IDLE && i_start;
  assign o_mem_rd   = state_q == FETCH && &room_w;
  assign o_mem_addr = cnt_q;
  assign o_done     = done_q;
  assign o_active   = active_q;
  assign o_r_vld    = vld_w[0];
  assign o_g_vld    = vld_w[1];
  assign o_b_vld    = vld_w[2];
  assign o_r_data   = head_w[0];
  assign o_g_data   = head_w[1];
  assign o_b_data   = head_w[2];

`ifdef RGB_PIXEL_SOURCE_GRAY_EN
  logic [9:0] y_w;
  assign y_w    = (10'(i_mem_rdata[23:16]) + {1'b0, i_mem_rdata[15:8], 1'b0} + 10'(i_mem_rdata[7:0])) >> 2;
  assign push_w = {3{y_w[7:0]}};
`else
  assign push_w = {i_mem_rdata[7:0], i_mem_rdata[15:8], i_mem_rdata[23:16]};
`endif

  always_comb begin
    state_d = state_q;
    len_d   = start_w ? i_frame_len : len_q;
    cnt_d   = start_w ? '0 : cnt_q + ADDR_W'(o_mem_rd);
    if (start_w) state_d = i_frame_len == '0 ? DONE : FETCH;
    else if (state_q == FETCH && o_mem_rd && cnt_d == len_q) state_d = DRAIN;
    else if (state_q == DRAIN && !pend_q && &empty_w) state_d = DONE;
    else if (state_q == DONE) state_d = IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      pend_q   <= o_mem_rd;
      done_q   <= state_q == DONE;
      active_q <= start_w | (active_q & ~done_q);
    end

  // Read gating counts the in-flight read so a push can never land on a full FIFO.
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [PW:0] wr_q, rd_q, cnt_w;
    logic [7:0]  mem_q [FIFO_DEPTH];
    assign cnt_w      = wr_q - rd_q;
    assign vld_w[c]   = cnt_w != '0;
    assign empty_w[c] = cnt_w == '0;
    assign head_w[c]  = mem_q[rd_q[PW-1:0]];
    assign room_w[c]  = ({1'b0, cnt_w} + {{(PW+1){1'b0}}, pend_q}) < (PW+2)'(FIFO_DEPTH);
    always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
        wr_q <= '0;
        rd_q <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
        if (pend_q) begin
          mem_q[wr_q[PW-1:0]] <= push_w[c];
          wr_q                <= wr_q + 1'b1;
        end
        if (vld_w[c] && !busy_w[c]) rd_q <= rd_q + 1'b1;
      end
  end
endmodule

// File: tb/tb_rgb_pixel_source.sv
// tb_rgb_pixel_source: randomized scoreboard bench; expected channel bytes are derived from the pixel memory contents.
module tb_rgb_pixel_source;
  logic        clk = 0, rst = 1, i_start = 0;
  logic [15:0] i_frame_len = '0;
  logic        o_active, o_done, o_mem_rd;
  logic [15:0] o_mem_addr;
  logic [23:0] i_mem_rdata = '0;
  logic        o_r_vld, o_g_vld, o_b_vld;
  logic [7:0]  o_r_data, o_g_data, o_b_data;
  logic        i_r_busy = 0, i_g_busy = 0, i_b_busy = 0;
  logic [23:0] pmem [256];
  logic [7:0]  exp_q [3][$];
  logic        rnd_busy = 0, g_hold = 0, b_hold = 0;
  logic [2:0]  prev_stall = '0;
  logic [7:0]  prev_d [3];
  int          passed = 0, total = 0, done_cnt = 0, rd_cnt = 0;
  logic [2:0]  vld_s, busy_s;
  logic [7:0]  dat_s [3];

  assign vld_s  = {o_b_vld, o_g_vld, o_r_vld};
  assign busy_s = {i_b_busy, i_g_busy, i_r_busy};
  assign dat_s[0] = o_r_data;
  assign dat_s[1] = o_g_data;
  assign dat_s[2] = o_b_data;

  rgb_pixel_source #(.ADDR_W(16), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_frame_len(i_frame_len),
    .o_active(o_active), .o_done(o_done), .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr),
    .i_mem_rdata(i_mem_rdata),
    .o_r_vld(o_r_vld), .o_r_data(o_r_data), .i_r_busy(i_r_busy),
    .o_g_vld(o_g_vld), .o_g_data(o_g_data), .i_g_busy(i_g_busy),
    .o_b_vld(o_b_vld), .o_b_data(o_b_data), .i_b_busy(i_b_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) i_mem_rdata <= pmem[o_mem_addr[7:0]];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each pixel yields one byte per channel, raw or luminance.
  task automatic push_exp(logic [23:0] p);
    int r, g, b, y;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
`ifdef RGB_PIXEL_SOURCE_GRAY_EN
    y = (r + 2 * g + b) / 4;
    r = y; g = y; b = y;
`endif
    exp_q[0].push_back(8'(r));
    exp_q[1].push_back(8'(g));
    exp_q[2].push_back(8'(b));
  endtask

  task automatic start_frame(int len);
    i_frame_len = 16'(len);
    i_start = 1;
    tick();
    i_start = 0;
  endtask

  task automatic wait_done(string name, int bound);
    for (int n = 0; n < bound && !o_done; n++) @(negedge clk);
    chk(name, 32'(o_done), 1);
    tick();
  endtask

  task automatic chk_queues(string name);
    for (int c = 0; c < 3; c++) chk($sformatf("%s_left%0d", name, c), exp_q[c].size(), 0);
  endtask

  task automatic chk_idle(string name);
    chk({name, "_active"}, 32'(o_active), 0);
    chk({name, "_done"}, 32'(o_done), 0);
    chk({name, "_rd"}, 32'(o_mem_rd), 0);
    chk({name, "_addr"}, 32'(o_mem_addr), 0);
    chk({name, "_vld"}, 32'(vld_s), 0);
    chk({name, "_data"}, {8'h0, o_r_data, o_g_data, o_b_data}, 0);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    i_r_busy = rnd_busy && ($urandom_range(0, 1) == 1);
    i_g_busy = g_hold || (rnd_busy && ($urandom_range(0, 1) == 1));
    i_b_busy = b_hold || (rnd_busy && ($urandom_range(0, 1) == 1));
  end

  // Monitor: pops the scoreboard on every transfer and checks hold-while-busy.
  initial forever begin
    @(negedge clk);
    if (rst) prev_stall = '0;
    else begin
      if (o_done) done_cnt++;
      if (o_mem_rd) rd_cnt++;
      for (int c = 0; c < 3; c++) begin
        if (prev_stall[c]) chk($sformatf("hold%0d", c), {vld_s[c], dat_s[c]}, {1'b1, prev_d[c]});
        if (vld_s[c] && !busy_s[c]) begin
          if (exp_q[c].size() == 0) chk($sformatf("sb_empty%0d", c), exp_q[c].size(), 1);
          else chk($sformatf("pix%0d", c), dat_s[c], exp_q[c].pop_front());
        end
        prev_stall[c] = vld_s[c] && busy_s[c];
        prev_d[c]     = dat_s[c];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) pmem[i] = '0;
    repeat (3) tick();
    @(negedge clk);
    chk_idle("reset");
    tick();
    rst = 0;
    tick();

    // Basic frame plus first-pixel latency
    pmem[0] = 24'h112233; pmem[1] = 24'h445566; pmem[2] = 24'h778899; pmem[3] = 24'hAABBCC;
    for (int i = 0; i < 4; i++) push_exp(pmem[i]);
    rd_cnt = 0; done_cnt = 0;
    start_frame(4);
    @(negedge clk);
    chk("lat_rd", 32'(o_mem_rd), 1);
    chk("lat_active", 32'(o_active), 1);
    tick(); @(negedge clk);
    chk("lat_vld2", 32'(o_r_vld), 0);
    tick(); @(negedge clk);
    chk("lat_vld3", 32'(o_r_vld), 1);
    wait_done("done4", 100);
    @(negedge clk);
    chk("active_off4", 32'(o_active), 0);
    tick();
    chk("done4_cnt", done_cnt, 1);
    chk("rd4_cnt", rd_cnt, 4);
    chk_queues("f4");

    // G stalled: reads stop at FIFO depth
    for (int i = 0; i < 8; i++) begin pmem[i] = $urandom; push_exp(pmem[i]); end
    g_hold = 1; rd_cnt = 0; done_cnt = 0;
    start_frame(8);
    repeat (30) tick();
    chk("stall_rd", rd_cnt, 4);
    chk("stall_r", exp_q[0].size(), 4);
    chk("stall_g", exp_q[1].size(), 8);
    chk("stall_b", exp_q[2].size(), 4);
    chk("stall_done", done_cnt, 0);
    g_hold = 0;
    wait_done("done8", 200);
    tick();
    chk("done8_cnt", done_cnt, 1);
    chk("rd8_cnt", rd_cnt, 8);
    chk_queues("f8");

    // Zero-length frame
    rd_cnt = 0; done_cnt = 0;
    start_frame(0);
    @(negedge clk);
    chk("z1_done", 32'(o_done), 0);
    chk("z1_active", 32'(o_active), 1);
    tick(); @(negedge clk);
    chk("z2_done", 32'(o_done), 1);
    chk("z2_active", 32'(o_active), 1);
    tick(); @(negedge clk);
    chk("z3_done", 32'(o_done), 0);
    chk("z3_active", 32'(o_active), 0);
    chk("z_rd", rd_cnt, 0);
    tick();

    // Restart while busy is ignored
    for (int i = 0; i < 6; i++) begin pmem[i] = $urandom; push_exp(pmem[i]); end
    rd_cnt = 0; done_cnt = 0;
    start_frame(6);
    tick();
    i_frame_len = 16'd2; i_start = 1;
    tick();
    i_start = 0;
    wait_done("done6", 100);
    tick();
    chk("rd6_cnt", rd_cnt, 6);
    chk("done6_cnt", done_cnt, 1);
    chk_queues("f6");

    // Reset while draining, then a fresh frame
    for (int i = 0; i < 3; i++) begin pmem[i] = $urandom; push_exp(pmem[i]); end
    b_hold = 1;
    start_frame(3);
    repeat (8) tick();
    chk("drain_active", 32'(o_active), 1);
    rst = 1;
    #2;
    @(negedge clk);
    chk_idle("midrst");
    for (int c = 0; c < 3; c++) exp_q[c].delete();
    b_hold = 0; done_cnt = 0;
    tick();
    rst = 0;
    repeat (5) tick();
    chk("rst_nodone", done_cnt, 0);
    pmem[0] = 24'hFF80FF; pmem[1] = 24'hFFFFFF;
    for (int i = 0; i < 2; i++) push_exp(pmem[i]);
    rd_cnt = 0;
    start_frame(2);
    wait_done("done2", 100);
    tick();
    chk("rd2_cnt", rd_cnt, 2);
    chk("done2_cnt", done_cnt, 1);
    chk_queues("f2");

    // Random busy on all channels
    for (int i = 0; i < 64; i++) begin pmem[i] = $urandom; push_exp(pmem[i]); end
    rnd_busy = 1; rd_cnt = 0; done_cnt = 0;
    start_frame(64);
    wait_done("done64", 2000);
    tick();
    rnd_busy = 0;
    chk("rd64_cnt", rd_cnt, 64);
    chk("done64_cnt", done_cnt, 1);
    chk_queues("f64");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
